// File: rtl/interpol_nx.sv
// interpol_nx: linear / zero-order-hold interpolator, ratio R = 2**LOG2R.
// A difference accumulator is re-anchored on every input sample, so rounding
// error never carries from one input period into the next.
module interpol_nx #(
  parameter int DW    = 18,
  parameter int LOG2R = 2,
  parameter int ROUND = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clkenin,
  input  logic                 clkenrx,
  input  logic                 mode,
  input  logic                 clrerr,
  input  logic signed [DW-1:0] xkin,
  output logic signed [DW-1:0] ykout,
  output logic                 yvalid,
  output logic [LOG2R-1:0]     phase,
  output logic                 syncerr
);

  if (LOG2R < 1 || LOG2R > 4) begin : g_bad_log2r
    $error("interpol_nx: LOG2R must be in 1..4");
  end

  localparam int AW     = DW + LOG2R + 1;
  localparam int RND_I  = (ROUND != 0) ? (1 << (LOG2R - 1)) : 0;
  localparam logic signed [AW-1:0]  RND     = AW'(RND_I);
  localparam logic [LOG2R-1:0]      PH_LAST = '1;

  logic signed [DW-1:0] r1, r2;
  logic                 mode_r;
  logic signed [AW-1:0] accum;
  logic signed [DW:0]   diff;
  logic signed [AW-1:0] anchor;
  logic signed [AW-1:0] acc_n;
  logic signed [AW-1:0] acc_rnd;
  logic [LOG2R-1:0]     phase_n;
  logic                 tick;
  logic                 set_err;
  logic                 mode_eff;
  logic signed [DW-1:0] lin_y;
  logic signed [DW-1:0] hold_y;

  assign tick    = clkenrx;
  assign diff    = {r1[DW-1], r1} - {r2[DW-1], r2};
  assign anchor  = AW'(r1) <<< LOG2R;
  assign acc_rnd = acc_n + RND;
  assign lin_y   = DW'(acc_rnd >>> LOG2R);
  // On an input cycle the register update makes r2 equal to the old r1.
  assign hold_y  = clkenin ? r1 : r2;
  // A new mode applies from the first tick of the period it arrives with, so
  // the whole period runs in one mode.
  assign mode_eff = clkenin ? mode : mode_r;

  // Next accumulator, next phase and rate-mismatch detection.
  always_comb begin
    acc_n   = accum;
    phase_n = phase;
    set_err = 1'b0;
    if (clkenin) begin
      acc_n   = anchor;
      phase_n = '0;
      if (!tick) set_err = 1'b1;
    end else if (tick) begin
      if (phase != PH_LAST) begin
        acc_n   = accum + AW'(diff);
        phase_n = phase + 1'b1;
      end else begin
        set_err = 1'b1;
      end
    end
  end

  // Sample history, accumulator, phase, output and sticky error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r1      <= '0;
      r2      <= '0;
      mode_r  <= 1'b0;
      accum   <= '0;
      phase   <= '0;
      ykout   <= '0;
      yvalid  <= 1'b0;
      syncerr <= 1'b0;
    end else begin
      if (clkenin) begin
        r2     <= r1;
        r1     <= xkin;
        mode_r <= mode;
      end
      if (clkenin || tick) begin
        accum <= acc_n;
        phase <= phase_n;
      end
      yvalid <= tick;
      if (tick) ykout <= mode_eff ? hold_y : lin_y;
      if (clrerr)       syncerr <= 1'b0;
      else if (set_err) syncerr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_interpol_nx.sv
// Bench for interpol_nx: six instances (LOG2R=2 truncating, LOG2R=2 rounding,
// LOG2R=1..4 truncating); expected outputs are queued as ticks are issued
// and a monitor pops them whenever yvalid is seen.
module tb_interpol_nx;

  logic clock = 1'b0;
  logic rst   = 1'b0;

  logic              cin [6];
  logic              crx [6];
  logic              md  [6];
  logic              clr [6];
  logic signed [17:0] xin [6];
  logic signed [17:0] yk  [6];
  logic              yv  [6];
  logic              se  [6];
  logic [3:0]        ph  [6];

  int eyq [6][$];
  int epq [6][$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 6; g++) begin : g_dut
    localparam int LR = (g < 2) ? 2 : g - 1;
    logic [LR-1:0] ph_l;
    interpol_nx #(.DW(18), .LOG2R(LR), .ROUND((g == 1) ? 1 : 0)) u_dut (
      .clock  (clock),
      .reset  (rst),
      .clkenin(cin[g]),
      .clkenrx(crx[g]),
      .mode   (md[g]),
      .clrerr (clr[g]),
      .xkin   (xin[g]),
      .ykout  (yk[g]),
      .yvalid (yv[g]),
      .phase  (ph_l),
      .syncerr(se[g])
    );
    assign ph[g] = 4'(ph_l);
  end

  function automatic int rof(input int u);
    return (u < 2) ? 4 : (1 << (u - 1));
  endfunction

  function automatic int floordiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_strobes();
    for (int i = 0; i < 6; i++) begin
      cin[i] = 1'b0;
      crx[i] = 1'b0;
      clr[i] = 1'b0;
    end
  endtask

  // One clock of stimulus to instance u; a tick queues its expected output.
  task automatic tick(input int u, input bit ci, input bit cr, input int x,
                      input bit m, input bit c, input int ey, input int ep);
    @(posedge clock);
    #1;
    clear_strobes();
    cin[u] = ci;
    crx[u] = cr;
    xin[u] = 18'(x);
    md[u]  = m;
    clr[u] = c;
    if (cr) begin
      eyq[u].push_back(ey);
      epq[u].push_back(ep);
    end
  endtask

  task automatic idle();
    @(posedge clock);
    #1;
    clear_strobes();
  endtask

  // Full input period for an R=4 instance with hand-computed outputs.
  task automatic period4(input int u, input int x, input bit m,
                         input int e0, input int e1, input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < 4; k++) tick(u, k == 0, 1'b1, x, m, 1'b0, e[k], k);
  endtask

  initial begin
    for (int i = 0; i < 6; i++) begin
      cin[i] = 1'b0; crx[i] = 1'b0; md[i] = 1'b0; clr[i] = 1'b0; xin[i] = '0;
    end

    fork
      forever begin
        @(negedge clock);
        for (int u = 0; u < 6; u++) begin
          if (yv[u] === 1'b1) begin
            int ey;
            int ep;
            n_cmp++;
            if (eyq[u].size() == 0) begin
              n_bad++;
              $display("FAIL u%0d unexpected yvalid: ykout=%0d phase=%0d, expected no output",
                       u, yk[u], ph[u]);
            end else begin
              ey = eyq[u].pop_front();
              ep = epq[u].pop_front();
              if (int'(yk[u]) != ey || int'(ph[u]) != ep) begin
                n_bad++;
                $display("FAIL u%0d output: ykout=%0d phase=%0d, expected ykout=%0d phase=%0d",
                         u, yk[u], ph[u], ey, ep);
              end
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    for (int u = 0; u < 6; u++) begin
      check($sformatf("u%0d reset ykout", u), int'(yk[u]), 0);
      check($sformatf("u%0d reset phase", u), int'(ph[u]), 0);
      check($sformatf("u%0d reset yvalid", u), int'(yv[u]), 0);
      check($sformatf("u%0d reset syncerr", u), int'(se[u]), 0);
    end
    rst = 1'b1;

    // Linear ramp 0 -> 400
    period4(0, 0,   1'b0, 0,   0,   0,   0);
    period4(0, 400, 1'b0, 0,   100, 200, 300);
    period4(0, 400, 1'b0, 400, 400, 400, 400);

    // Truncation: 400 -> -3 -> -3 -> 0
    period4(0, -3, 1'b0, 400, 299, 198, 97);
    period4(0, -3, 1'b0, -3,  -3,  -3,  -3);
    period4(0, 0,  1'b0, -3,  -3,  -2,  -1);
    period4(0, 0,  1'b0, 0,   0,   0,   0);

    // Rounding instance: 0 -> -3 -> -3 -> 0
    period4(1, -3, 1'b0, 0,  -1, -1, -2);
    period4(1, -3, 1'b0, -3, -3, -3, -3);
    period4(1, 0,  1'b0, -3, -2, -1, -1);
    period4(1, 0,  1'b0, 0,  0,  0,  0);

    // Zero-order hold, then back to linear
    period4(0, 100, 1'b1, 0,   0,   0,   0);
    period4(0, -50, 1'b1, 100, 100, 100, 100);
    period4(0, -50, 1'b1, -50, -50, -50, -50);
    period4(0, 0,   1'b0, -50, -38, -25, -13);
    period4(0, 0,   1'b0, 0,   0,   0,   0);

    // Full-scale swing at every ratio
    for (int u = 2; u < 6; u++) begin
      int xs [3];
      int x0;
      xs = '{131071, -131072, -131072};
      x0 = 0;
      for (int p = 0; p < 3; p++) begin
        for (int k = 0; k < rof(u); k++)
          tick(u, k == 0, 1'b1, xs[p], 1'b0, 1'b0,
               x0 + floordiv(k * (xs[p] - x0), rof(u)), k);
        x0 = xs[p];
      end
    end
    idle();

    // Missing input sample: phase sticks, output holds, flag sets
    period4(0, 400, 1'b0, 0, 100, 200, 300);
    for (int k = 0; k < 4; k++) tick(0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 300, 3);
    idle();
    check("missing input syncerr", int'(se[0]), 1);
    check("missing input phase", int'(ph[0]), 3);
    period4(0, 800, 1'b0, 400, 500, 600, 700);
    idle();
    check("syncerr sticky", int'(se[0]), 1);
    tick(0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 0, 0);
    idle();
    check("clrerr clears", int'(se[0]), 0);
    tick(0, 1'b1, 1'b0, 800, 1'b0, 1'b1, 0, 0);
    idle();
    check("clrerr beats set", int'(se[0]), 0);
    tick(0, 1'b1, 1'b0, 800, 1'b0, 1'b0, 0, 0);
    idle();
    check("input without tick syncerr", int'(se[0]), 1);
    check("input without tick phase", int'(ph[0]), 0);

    // Reset mid-period at phase 2
    tick(0, 1'b1, 1'b1, 1000, 1'b0, 1'b0, 800, 0);
    tick(0, 1'b0, 1'b1, 1000, 1'b0, 1'b0, 850, 1);
    tick(0, 1'b0, 1'b1, 1000, 1'b0, 1'b0, 900, 2);
    idle();
    check("pre-reset ykout", int'(yk[0]), 900);
    check("pre-reset phase", int'(ph[0]), 2);
    @(negedge clock);
    #2;
    rst = 1'b0;
    #1;
    check("async reset ykout", int'(yk[0]), 0);
    check("async reset phase", int'(ph[0]), 0);
    check("async reset syncerr", int'(se[0]), 0);
    check("async reset yvalid", int'(yv[0]), 0);
    @(posedge clock);
    #1;
    rst = 1'b1;
    period4(0, 400, 1'b0, 0, 100, 200, 300);

    repeat (3) idle();
    for (int u = 0; u < 6; u++)
      check($sformatf("u%0d outputs still pending", u), eyq[u].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
